// File: rtl/sync_fifo_prog.sv
// Single-clock FIFO with standard or first-word-fall-through read, programmable
// almost-full/almost-empty thresholds and a fill level. Define FIFO_STICKY_ERR_EN for sticky overflow/underflow.
module sync_fifo_prog #(
  parameter int DATA_WIDTH = 16,
  parameter int FIFO_DEPTH = 8,
  parameter int FWFT       = 0,
  localparam int AW        = $clog2(FIFO_DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  rd_en,
  input  logic [AW:0]           af_thresh,
  input  logic [AW:0]           ae_thresh,
  input  logic                  err_clr,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  rd_valid,
  output logic                  wr_ack,
  output logic                  overflow,
  output logic                  underflow,
  output logic                  full,
  output logic                  empty,
  output logic                  almostfull,
  output logic                  almostempty,
  output logic [AW:0]           level
);

  localparam logic [AW-1:0] LAST_PTR  = AW'(FIFO_DEPTH - 1);
  localparam logic [AW:0]   DEPTH_CNT = (AW+1)'(FIFO_DEPTH);

  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;
  logic [AW:0]           count;
  logic                  rd_acc;
  logic                  wr_acc;
  logic                  ovf_ev;
  logic                  unf_ev;

  // A write into a full FIFO still fits when a read frees a slot in the same cycle.
  assign rd_acc = rd_en && (count != '0);
  assign wr_acc = wr_en && ((count < DEPTH_CNT) || rd_acc);
  assign ovf_ev = wr_en && !wr_acc;
  assign unf_ev = rd_en && !rd_acc;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      wr_ack <= 1'b0;
    end else begin
      if (wr_acc) wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + 1'b1;
      if (rd_acc) rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + 1'b1;
      if (wr_acc && !rd_acc)      count <= count + 1'b1;
      else if (rd_acc && !wr_acc) count <= count - 1'b1;
      wr_ack <= wr_acc;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_acc) mem[wr_ptr] <= data_in;
  end

`ifdef FIFO_STICKY_ERR_EN
  // A new event in the same cycle as err_clr keeps the flag set.
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      overflow  <= ovf_ev || (overflow && !err_clr);
      underflow <= unf_ev || (underflow && !err_clr);
    end
  end
`else
  logic unused_err_clr;
  assign unused_err_clr = err_clr;

  always_ff @(posedge clk) begin
    if (rst) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      overflow  <= ovf_ev;
      underflow <= unf_ev;
    end
  end
`endif

  generate
    if (FWFT != 0) begin : g_fwft
      assign data_out = mem[rd_ptr];
      assign rd_valid = (count != '0);
    end else begin : g_std
      always_ff @(posedge clk) begin
        if (rst) begin
          data_out <= '0;
          rd_valid <= 1'b0;
        end else begin
          rd_valid <= rd_acc;
          if (rd_acc) data_out <= mem[rd_ptr];
        end
      end
    end
  endgenerate

  assign full        = (count == DEPTH_CNT);
  assign empty       = (count == '0);
  assign almostfull  = (count >= af_thresh);
  assign almostempty = (count <= ae_thresh);
  assign level       = count;

endmodule

// File: tb/tb_sync_fifo_prog.sv
// Bench for sync_fifo_prog: a standard-read depth-8 instance and an FWFT depth-5 instance,
// checked every cycle against queue models plus directed literal expectations.
module tb_sync_fifo_prog;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b1;
  logic err_clr = 1'b0;

  logic        wr0 = 1'b0, rd0 = 1'b0;
  logic [15:0] din0 = '0;
  logic [3:0]  af0 = 4'd6, ae0 = 4'd2;
  logic [15:0] dout0;
  logic        rv0, ack0, ovf0, unf0, full0, empty0, afl0, ael0;
  logic [3:0]  lvl0;

  logic        wr1 = 1'b0, rd1 = 1'b0;
  logic [15:0] din1 = '0;
  logic [3:0]  af1 = 4'd4, ae1 = 4'd1;
  logic [15:0] dout1;
  logic        rv1, ack1, ovf1, unf1, full1, empty1, afl1, ael1;
  logic [3:0]  lvl1;

  sync_fifo_prog #(.DATA_WIDTH(16), .FIFO_DEPTH(8), .FWFT(0)) dut0 (
    .clk(clk), .rst(rst), .wr_en(wr0), .data_in(din0), .rd_en(rd0),
    .af_thresh(af0), .ae_thresh(ae0), .err_clr(err_clr),
    .data_out(dout0), .rd_valid(rv0), .wr_ack(ack0), .overflow(ovf0), .underflow(unf0),
    .full(full0), .empty(empty0), .almostfull(afl0), .almostempty(ael0), .level(lvl0));

  sync_fifo_prog #(.DATA_WIDTH(16), .FIFO_DEPTH(5), .FWFT(1)) dut1 (
    .clk(clk), .rst(rst), .wr_en(wr1), .data_in(din1), .rd_en(rd1),
    .af_thresh(af1), .ae_thresh(ae1), .err_clr(err_clr),
    .data_out(dout1), .rd_valid(rv1), .wr_ack(ack1), .overflow(ovf1), .underflow(unf1),
    .full(full1), .empty(empty1), .almostfull(afl1), .almostempty(ael1), .level(lvl1));

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic bit err_next(input bit ev, input bit prev, input bit clr);
`ifdef FIFO_STICKY_ERR_EN
    return ev || (prev && !clr);
`else
    return ev;
`endif
  endfunction

  // Reference model: plain queues with accept rules applied directly.
  logic [15:0] q0[$];
  logic [15:0] q1[$];
  bit          m_started = 0;
  logic [15:0] m_dout0 = '0;
  bit          m_rv0 = 0, m_ack0 = 0, m_ovf0 = 0, m_unf0 = 0;
  bit          m_ack1 = 0, m_ovf1 = 0, m_unf1 = 0;

  always @(posedge clk) begin : model
    bit ra, wa;
    if (rst) begin
      q0.delete(); q1.delete();
      m_dout0 = '0; m_rv0 = 0; m_ack0 = 0; m_ovf0 = 0; m_unf0 = 0;
      m_ack1 = 0; m_ovf1 = 0; m_unf1 = 0;
      m_started = 1;
    end else begin
      ra = rd0 && (q0.size() != 0);
      wa = wr0 && ((q0.size() < 8) || ra);
      m_rv0 = ra;
      if (ra) m_dout0 = q0.pop_front();
      if (wa) q0.push_back(din0);
      m_ack0 = wa;
      m_ovf0 = err_next(wr0 && !wa, m_ovf0, err_clr);
      m_unf0 = err_next(rd0 && !ra, m_unf0, err_clr);

      ra = rd1 && (q1.size() != 0);
      wa = wr1 && ((q1.size() < 5) || ra);
      if (ra) void'(q1.pop_front());
      if (wa) q1.push_back(din1);
      m_ack1 = wa;
      m_ovf1 = err_next(wr1 && !wa, m_ovf1, err_clr);
      m_unf1 = err_next(rd1 && !ra, m_unf1, err_clr);
    end
  end

  always @(negedge clk) begin
    if (m_started) begin
      chk("m_level0", lvl0, q0.size());
      chk("m_full0", full0, q0.size() == 8);
      chk("m_empty0", empty0, q0.size() == 0);
      chk("m_afull0", afl0, q0.size() >= af0);
      chk("m_aempty0", ael0, q0.size() <= ae0);
      chk("m_dout0", dout0, m_dout0);
      chk("m_rvalid0", rv0, m_rv0);
      chk("m_wrack0", ack0, m_ack0);
      chk("m_ovf0", ovf0, m_ovf0);
      chk("m_unf0", unf0, m_unf0);
      chk("m_level1", lvl1, q1.size());
      chk("m_full1", full1, q1.size() == 5);
      chk("m_empty1", empty1, q1.size() == 0);
      chk("m_afull1", afl1, q1.size() >= af1);
      chk("m_aempty1", ael1, q1.size() <= ae1);
      chk("m_rvalid1", rv1, q1.size() != 0);
      if (q1.size() != 0) chk("m_dout1", dout1, q1[0]);
      chk("m_wrack1", ack1, m_ack1);
      chk("m_ovf1", ovf1, m_ovf1);
      chk("m_unf1", unf1, m_unf1);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic clear_errs();
    err_clr = 1'b1;
    cyc();
    err_clr = 1'b0;
  endtask

  initial begin : stim
    int npop;
    rst = 1'b1;
    cyc(); cyc();
    rst = 1'b0;
    cyc();
    chk("rst_level", lvl0, 0);
    chk("rst_empty", empty0, 1);
    chk("rst_full", full0, 0);

    // fill 0x1000..0x1007 with threshold checks along the way
    for (int i = 0; i < 8; i++) begin
      wr0 = 1'b1; din0 = 16'(32'h1000 + i);
      cyc();
      chk("fill_ack", ack0, 1);
      if (i == 1) chk("ae_lvl2", ael0, 1);
      if (i == 2) chk("ae_lvl3", ael0, 0);
      if (i == 4) chk("af_lvl5", afl0, 0);
      if (i == 5) chk("af_lvl6", afl0, 1);
    end
    chk("fill_full", full0, 1);
    chk("fill_level", lvl0, 8);
    din0 = 16'h1008;
    cyc();
    chk("ovf_set", ovf0, 1);
    chk("ovf_ack", ack0, 0);
    chk("ovf_level", lvl0, 8);
    wr0 = 1'b0;
    clear_errs();

    for (int i = 0; i < 8; i++) begin
      rd0 = 1'b1;
      cyc();
      chk("drain_data", dout0, 32'h1000 + i);
      chk("drain_valid", rv0, 1);
    end
    cyc();
    chk("unf_set", unf0, 1);
    chk("unf_valid", rv0, 0);
    chk("unf_hold", dout0, 16'h1007);
    rd0 = 1'b0;
    clear_errs();

    // read and write together while full
    for (int i = 0; i < 8; i++) begin
      wr0 = 1'b1; din0 = 16'(32'h3000 + i);
      cyc();
    end
    rd0 = 1'b1; din0 = 16'h2000;
    cyc();
    chk("rwfull_ovf", ovf0, 0);
    chk("rwfull_ack", ack0, 1);
    chk("rwfull_level", lvl0, 8);
    chk("rwfull_data", dout0, 16'h3000);
    wr0 = 1'b0;
    for (int i = 0; i < 8; i++) begin
      cyc();
      chk("rwfull_order", dout0, (i < 7) ? 32'h3001 + i : 32'h2000);
    end
    rd0 = 1'b0;
    cyc();

    // write and read together while empty
    wr0 = 1'b1; rd0 = 1'b1; din0 = 16'h4000;
    cyc();
    chk("rwempty_unf", unf0, 1);
    chk("rwempty_ack", ack0, 1);
    chk("rwempty_level", lvl0, 1);
    wr0 = 1'b0;
    cyc();
    chk("rwempty_data", dout0, 16'h4000);
    rd0 = 1'b0;
    clear_errs();

    // threshold extremes
    af0 = 4'd0; ae0 = 4'd8;
    cyc();
    chk("af0_always", afl0, 1);
    chk("ae8_always", ael0, 1);
    af0 = 4'd9;
    for (int i = 0; i < 8; i++) begin
      wr0 = 1'b1; din0 = 16'(32'h6000 + i);
      cyc();
    end
    wr0 = 1'b0;
    chk("af9_never", afl0, 0);
    chk("ae8_full", ael0, 1);
    chk("af9_full", full0, 1);

    // reset mid-operation at level 5
    af0 = 4'd6; ae0 = 4'd2;
    rd0 = 1'b1;
    repeat (3) cyc();
    rd0 = 1'b0;
    cyc();
    chk("pre_rst_level", lvl0, 5);
    rst = 1'b1; wr0 = 1'b1; rd0 = 1'b1;
    cyc();
    rst = 1'b0; wr0 = 1'b0; rd0 = 1'b0;
    chk("mid_rst_level", lvl0, 0);
    chk("mid_rst_empty", empty0, 1);
    chk("mid_rst_full", full0, 0);
    chk("mid_rst_valid", rv0, 0);
    chk("mid_rst_ack", ack0, 0);
    chk("mid_rst_ovf", ovf0, 0);
    chk("mid_rst_unf", unf0, 0);
    chk("mid_rst_dout", dout0, 0);

    rd0 = 1'b1;
    cyc();
    rd0 = 1'b0;
    chk("err_unf_set", unf0, 1);
`ifdef FIFO_STICKY_ERR_EN
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("sticky_hold", unf0, 1);
    end
    clear_errs();
    chk("sticky_clr", unf0, 0);
    rd0 = 1'b1; err_clr = 1'b1;
    cyc();
    rd0 = 1'b0; err_clr = 1'b0;
    chk("sticky_set_wins", unf0, 1);
    clear_errs();
    chk("sticky_clr2", unf0, 0);
`else
    cyc();
    chk("pulse_unf_drop", unf0, 0);
    err_clr = 1'b1;
    cyc();
    err_clr = 1'b0;
    chk("pulse_clr_ignored", unf0, 0);
`endif

    // FWFT instance, depth 5
    wr1 = 1'b1; din1 = 16'hABCD;
    cyc();
    wr1 = 1'b0;
    chk("fwft_valid", rv1, 1);
    chk("fwft_data", dout1, 16'hABCD);
    cyc();
    chk("fwft_data_hold", dout1, 16'hABCD);
    rd1 = 1'b1;
    cyc();
    rd1 = 1'b0;
    chk("fwft_pop_empty", empty1, 1);
    chk("fwft_pop_valid", rv1, 0);

    npop = 0;
    for (int k = 0; k < 20; k++) begin
      wr1 = 1'b1; din1 = 16'(32'h5000 + k);
      rd1 = (k >= 2);
      if (rd1) begin
        chk("stream_data", dout1, 32'h5000 + npop);
        npop++;
      end
      cyc();
    end
    wr1 = 1'b0;
    for (int j = 0; j < 10 && npop < 20; j++) begin
      rd1 = 1'b1;
      chk("stream_tail", dout1, 32'h5000 + npop);
      npop++;
      cyc();
    end
    rd1 = 1'b0;
    chk("stream_empty", empty1, 1);

    for (int i = 0; i < 5; i++) begin
      wr1 = 1'b1; din1 = 16'(32'h7000 + i);
      cyc();
    end
    chk("fwft_full", full1, 1);
    chk("fwft_full_level", lvl1, 5);
    din1 = 16'h7005;
    cyc();
    wr1 = 1'b0;
    chk("fwft_ovf", ovf1, 1);
    chk("fwft_ovf_level", lvl1, 5);
    chk("fwft_head", dout1, 16'h7000);
    cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
